// File: rtl/sensor_scan_pkg.sv
// ---------------------------------------------------------------------------
// sensor_scan_pkg
// Shared types and constants for the sensor scan scheduler:
//   - scan_state_e : scheduler FSM state encoding
//   - CH_*         : channel index of each threshold channel
//   - NUM_CH_C     : number of channels that have a threshold input
//   - CH_W         : width of the channel index on the sample interface
// ---------------------------------------------------------------------------
package sensor_scan_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CMP  = 3'd2,
    NEXT = 3'd3,
    GAP  = 3'd4
  } scan_state_e;

  localparam int CH_TEMP     = 0;
  localparam int CH_HUMIDITY = 1;
  localparam int CH_DEW      = 2;
  localparam int CH_SOIL     = 3;
  localparam int CH_WATER    = 4;

  localparam int NUM_CH_C    = 5;
  localparam int CH_W        = 3;

endpackage

// File: rtl/sensor_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// sensor_scan_ctrl_if
// Request/acknowledge sample interface between the scan scheduler and the
// sensor acquisition front-end.
//   smp_req  : scheduler -> front-end, held until ack or timeout
//   smp_ch   : scheduler -> front-end, channel index, stable while smp_req=1
//   smp_ack  : front-end -> scheduler, 1-cycle pulse
//   smp_data : front-end -> scheduler, unsigned sample, valid with smp_ack
// Modports: master (scheduler side), slave (front-end side).
// ---------------------------------------------------------------------------
interface sensor_scan_ctrl_if #(
  parameter int DATA_W = 32
);
  logic                smp_req;
  logic [2:0]          smp_ch;
  logic                smp_ack;
  logic [DATA_W-1:0]   smp_data;

  modport master (
    output smp_req,
    output smp_ch,
    input  smp_ack,
    input  smp_data
  );

  modport slave (
    input  smp_req,
    input  smp_ch,
    output smp_ack,
    output smp_data
  );
endinterface

// File: rtl/sensor_scan_ctrl_alarm_persist.sv
// ---------------------------------------------------------------------------
// alarm_persist
// Per-channel debounce: counts consecutive samples above the threshold and
// raises a persistent alarm once PERSIST of them have been seen.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   upd        : 1-cycle strobe, evaluate sample against threshold
//   sample     : captured sample (unsigned)
//   threshold  : live channel threshold (unsigned)
//   alarm      : debounced alarm output
// Optional feature macro: SENSOR_SCAN_HYSTERESIS_EN
//   When defined, a sample that is not above the threshold but is at or
//   above (threshold - HYST, floored at 0) holds both counter and alarm;
//   only samples below that level clear them.
// ---------------------------------------------------------------------------
module alarm_persist #(
  parameter int DATA_W  = 32,
  parameter int PERSIST = 3,
  parameter int HYST    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] threshold,
  output logic              alarm
);

`ifdef SENSOR_SCAN_HYSTERESIS_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif

  localparam logic [3:0]        PERSIST_C = 4'(PERSIST);
  localparam logic [DATA_W-1:0] HYST_C    = DATA_W'(HYST);

  logic [3:0]        cnt_q, cnt_d;
  logic              alarm_q, alarm_d;
  logic [DATA_W-1:0] clr_lvl;
  logic              exceed;
  logic              in_band;

  always_comb begin
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    exceed  = sample > threshold;
    clr_lvl = (threshold >= HYST_C) ? (threshold - HYST_C) : '0;
    in_band = HYST_EN && (sample >= clr_lvl);

    if (upd) begin
      if (exceed) begin
        // Saturate at PERSIST; alarm sets on the sample that reaches it.
        if (cnt_q < PERSIST_C) begin
          cnt_d = cnt_q + 4'd1;
        end
        if (cnt_q >= PERSIST_C - 4'd1) begin
          alarm_d = 1'b1;
        end
      end else if (!in_band) begin
        cnt_d   = '0;
        alarm_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;

endmodule

// File: rtl/sensor_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sensor_scan_ctrl
// Round-robin scan scheduler for the temp/humidity/dew/soil/water channels.
// Requests one sample per channel over the smp interface, compares each
// sample against its CSR threshold and debounces exceedances into alarms.
// Ports:
//   clk_sys, reset_clk_sys_n : clock, asynchronous active-low reset
//   scan_en                  : level, run continuous scans
//   *_threshold              : per-channel thresholds, read live in CMP
//   smp (master)             : sample req/ack interface
//   alarm                    : per-channel debounced alarms
//   scan_done                : 1-cycle pulse after the last channel of a scan
//   timeout_err              : sticky per-channel ack timeout flags
//   err_clr                  : clears timeout_err (a same-cycle set wins)
// Optional feature macro: SENSOR_SCAN_HYSTERESIS_EN (see alarm_persist).
// NUM_CH must equal the number of threshold ports (5).
// ---------------------------------------------------------------------------
module sensor_scan_ctrl
  import sensor_scan_pkg::*;
#(
  parameter int NUM_CH   = 5,
  parameter int DATA_W   = 32,
  parameter int PERSIST  = 3,
  parameter int SCAN_GAP = 16,
  parameter int TIMEOUT  = 255,
  parameter int HYST     = 4
) (
  input  logic              clk_sys,
  input  logic              reset_clk_sys_n,
  input  logic              scan_en,
  input  logic [DATA_W-1:0] temp_threshold,
  input  logic [DATA_W-1:0] humidity_threshold,
  input  logic [DATA_W-1:0] dew_threshold,
  input  logic [DATA_W-1:0] soil_threshold,
  input  logic [DATA_W-1:0] water_threshold,
  sensor_scan_ctrl_if.master smp,
  output logic [NUM_CH-1:0] alarm,
  output logic              scan_done,
  output logic [NUM_CH-1:0] timeout_err,
  input  logic              err_clr
);

  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0]     GAP_LAST = 16'(SCAN_GAP - 1);

  scan_state_e       state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [15:0]       cnt_q, cnt_d;      // ack wait count in REQ, gap count in GAP
  logic [DATA_W-1:0] data_q, data_d;
  logic [NUM_CH-1:0] terr_q, terr_d;
  logic [NUM_CH-1:0] upd;
  logic [DATA_W-1:0] thr [NUM_CH_C];

  assign thr[CH_TEMP]     = temp_threshold;
  assign thr[CH_HUMIDITY] = humidity_threshold;
  assign thr[CH_DEW]      = dew_threshold;
  assign thr[CH_SOIL]     = soil_threshold;
  assign thr[CH_WATER]    = water_threshold;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    terr_d    = err_clr ? '0 : terr_q;
    upd       = '0;
    scan_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d = REQ;
          ch_d    = '0;
          cnt_d   = '0;
        end
      end

      REQ: begin
        // An ack on the final wait cycle is still accepted.
        if (smp.smp_ack) begin
          data_d  = smp.smp_data;
          state_d = CMP;
        end else if (cnt_q == TO_LAST) begin
          terr_d[ch_q] = 1'b1;
          state_d      = NEXT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      CMP: begin
        upd[ch_q] = 1'b1;
        state_d   = NEXT;
      end

      NEXT: begin
        cnt_d = '0;
        // scan_en is checked only here, so a dropped enable still lets the
        // in-flight channel finish before returning to IDLE.
        if (!scan_en) begin
          state_d = IDLE;
          ch_d    = '0;
        end else if (ch_q != LAST_CH) begin
          ch_d    = ch_q + CH_W'(1);
          state_d = REQ;
        end else begin
          scan_done = 1'b1;
          ch_d      = '0;
          state_d   = (SCAN_GAP > 0) ? GAP : REQ;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = scan_en ? REQ : IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
        ch_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_clk_sys_n) begin
    if (!reset_clk_sys_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      terr_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      terr_q  <= terr_d;
    end
  end

  // Request is decoded from the state flop so an asynchronous reset drops it
  // immediately.
  assign smp.smp_req  = (state_q == REQ);
  assign smp.smp_ch   = ch_q;
  assign timeout_err  = terr_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    alarm_persist #(
      .DATA_W  (DATA_W),
      .PERSIST (PERSIST),
      .HYST    (HYST)
    ) u_alarm_persist (
      .clk       (clk_sys),
      .rst_n     (reset_clk_sys_n),
      .upd       (upd[i]),
      .sample    (data_q),
      .threshold (thr[i]),
      .alarm     (alarm[i])
    );
  end

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sensor_scan_ctrl
// Directed bench for sensor_scan_ctrl with default parameters
// (PERSIST=3, SCAN_GAP=16, TIMEOUT=255, HYST=4). The bench plays the sensor
// front-end; inputs change and outputs are sampled on the falling edge.
// Expected alarm values depend on SENSOR_SCAN_HYSTERESIS_EN where noted.
// ---------------------------------------------------------------------------
module tb_sensor_scan_ctrl;

`ifdef SENSOR_SCAN_HYSTERESIS_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  logic        clk_sys;
  logic        reset_clk_sys_n;
  logic        scan_en;
  logic        err_clr;
  logic [31:0] thr_val;
  logic [4:0]  alarm;
  logic        scan_done;
  logic [4:0]  timeout_err;

  int errors = 0;
  int checks = 0;

  sensor_scan_ctrl_if #(.DATA_W(32)) smp_if ();

  sensor_scan_ctrl dut (
    .clk_sys            (clk_sys),
    .reset_clk_sys_n    (reset_clk_sys_n),
    .scan_en            (scan_en),
    .temp_threshold     (thr_val),
    .humidity_threshold (thr_val),
    .dew_threshold      (thr_val),
    .soil_threshold     (thr_val),
    .water_threshold    (thr_val),
    .smp                (smp_if.master),
    .alarm              (alarm),
    .scan_done          (scan_done),
    .timeout_err        (timeout_err),
    .err_clr            (err_clr)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a request and confirm which channel it targets.
  task automatic wait_req(input logic [2:0] ch);
    int n = 0;
    while (smp_if.smp_req !== 1'b1 && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    chk($sformatf("ch%0d_req_seen", ch), {31'd0, smp_if.smp_req}, 32'd1);
    chk($sformatf("ch%0d_req_ch", ch), {29'd0, smp_if.smp_ch}, {29'd0, ch});
  endtask

  // Answer one request with a sample; returns at the falling edge of CMP.
  task automatic serve(input logic [2:0] ch, input logic [31:0] d);
    wait_req(ch);
    smp_if.smp_ack  = 1'b1;
    smp_if.smp_data = d;
    @(negedge clk_sys);
    smp_if.smp_ack  = 1'b0;
    smp_if.smp_data = '0;
    chk($sformatf("ch%0d_req_drop", ch), {31'd0, smp_if.smp_req}, 32'd0);
  endtask

  task automatic do_scan(input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3,
                         input logic [31:0] d4, input logic [4:0] exp_alarm,
                         input string tag);
    serve(3'd0, d0);
    serve(3'd1, d1);
    serve(3'd2, d2);
    serve(3'd3, d3);
    serve(3'd4, d4);
    @(negedge clk_sys);
    chk({tag, "_scan_done"}, {31'd0, scan_done}, 32'd1);
    chk({tag, "_alarm"}, {27'd0, alarm}, {27'd0, exp_alarm});
  endtask

  initial begin
    int n;
    reset_clk_sys_n = 1'b0;
    scan_en         = 1'b0;
    err_clr         = 1'b0;
    thr_val         = 32'd100;
    smp_if.smp_ack  = 1'b0;
    smp_if.smp_data = '0;

    repeat (2) @(negedge clk_sys);
    chk("rst_req", {31'd0, smp_if.smp_req}, 32'd0);
    chk("rst_ch", {29'd0, smp_if.smp_ch}, 32'd0);
    chk("rst_alarm", {27'd0, alarm}, 32'd0);
    chk("rst_done", {31'd0, scan_done}, 32'd0);
    chk("rst_terr", {27'd0, timeout_err}, 32'd0);
    reset_clk_sys_n = 1'b1;
    @(negedge clk_sys);
    chk("idle_no_req", {31'd0, smp_if.smp_req}, 32'd0);

    // A: all below threshold, then measure the inter-scan gap.
    scan_en = 1'b1;
    do_scan(32'd50, 32'd50, 32'd50, 32'd50, 32'd50, 5'b00000, "A");
    @(negedge clk_sys);
    chk("A_done_pulse", {31'd0, scan_done}, 32'd0);
    n = 0;
    while (smp_if.smp_req !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk_sys);
    end
    chk("gap_len", n, 32'd16);

    // B..D: ch1 exceeds three times; alarm appears at the end of the 3rd CMP.
    do_scan(32'd50, 32'd101, 32'd50, 32'd50, 32'd50, 5'b00000, "B");
    do_scan(32'd50, 32'd101, 32'd50, 32'd101, 32'd50, 5'b00000, "C");
    serve(3'd0, 32'd50);
    serve(3'd1, 32'd101);
    chk("lat_in_cmp", {27'd0, alarm}, 32'd0);
    @(negedge clk_sys);
    chk("lat_after_cmp", {27'd0, alarm}, 32'b00010);
    serve(3'd2, 32'd50);
    serve(3'd3, 32'd101);
    serve(3'd4, 32'd50);
    @(negedge clk_sys);
    chk("D_scan_done", {31'd0, scan_done}, 32'd1);
    chk("D_alarm", {27'd0, alarm}, 32'b00010);

    // E: ch1 equal to threshold (clears unless in the hysteresis band),
    // ch3 drops to 90 so its count restarts; ch0 starts counting.
    do_scan(32'd101, 32'd100, 32'd50, 32'd90, 32'd50,
            HYST_ON ? 5'b00010 : 5'b00000, "E");
    do_scan(32'd101, 32'd50, 32'd50, 32'd101, 32'd50, 5'b00000, "F");
    do_scan(32'd101, 32'd50, 32'd50, 32'd101, 32'd101, 5'b00001, "G");

    // H: ch0=97 (hysteresis holds), ch2 never acked -> timeout. err_clr in
    // the final wait cycle must lose to the timeout set.
    serve(3'd0, 32'd97);
    serve(3'd1, 32'd50);
    wait_req(3'd2);
    n = 0;
    while (smp_if.smp_req === 1'b1 && n < 400) begin
      n++;
      if (n == 255) err_clr = 1'b1;
      @(negedge clk_sys);
      err_clr = 1'b0;
    end
    chk("to_req_len", n, 32'd255);
    chk("to_flag", {27'd0, timeout_err}, 32'b00100);
    serve(3'd3, 32'd50);
    serve(3'd4, 32'd101);
    @(negedge clk_sys);
    chk("H_scan_done", {31'd0, scan_done}, 32'd1);
    chk("H_alarm", {27'd0, alarm}, HYST_ON ? 32'b00001 : 32'b00000);
    chk("to_sticky", {27'd0, timeout_err}, 32'b00100);
    @(negedge clk_sys);
    err_clr = 1'b1;
    @(negedge clk_sys);
    err_clr = 1'b0;
    chk("err_clr", {27'd0, timeout_err}, 32'd0);

    // I: ch0=95 clears in both builds; ch4 reaches PERSIST.
    do_scan(32'd95, 32'd50, 32'd50, 32'd50, 32'd101, 5'b10000, "I");

    // J: scan_en dropped while ch2 waits; late ack, CMP, then IDLE.
    serve(3'd0, 32'd50);
    serve(3'd1, 32'd50);
    wait_req(3'd2);
    scan_en = 1'b0;
    repeat (10) @(negedge clk_sys);
    chk("J_req_held", {31'd0, smp_if.smp_req}, 32'd1);
    smp_if.smp_ack  = 1'b1;
    smp_if.smp_data = 32'd101;
    @(negedge clk_sys);
    smp_if.smp_ack  = 1'b0;
    smp_if.smp_data = '0;
    @(negedge clk_sys);
    chk("J_no_done", {31'd0, scan_done}, 32'd0);
    @(negedge clk_sys);
    chk("J_idle_req", {31'd0, smp_if.smp_req}, 32'd0);
    chk("J_idle_ch", {29'd0, smp_if.smp_ch}, 32'd0);
    chk("J_alarm_held", {27'd0, alarm}, 32'b10000);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (smp_if.smp_req === 1'b1 || scan_done === 1'b1) n++;
    end
    chk("J_idle_quiet", n, 32'd0);

    // Reset during a handshake drops the request without a clock edge.
    scan_en = 1'b1;
    wait_req(3'd0);
    #2 reset_clk_sys_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, smp_if.smp_req}, 32'd0);
    chk("async_rst_alarm", {27'd0, alarm}, 32'd0);
    @(negedge clk_sys);
    scan_en = 1'b0;
    reset_clk_sys_n = 1'b1;
    @(negedge clk_sys);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_scan_ctrl.md
Name: sensor_scan_ctrl

Overview:
Scan scheduler that sequences sensor sampling for the five threshold channels: temp, humidity, dew, soil and water.
- Requests one sample per channel, round-robin, over a req/ack handshake to the sensor front-end.
- Compares each returned sample against the programmed CSR threshold for that channel.
- Debounces exceedances into persistent alarm outputs.
- Sits between the CSR threshold register block and the sensor acquisition interface.

Parameters:
NUM_CH, 5, number of scanned channels (0=temp, 1=humidity, 2=dew, 3=soil, 4=water)
DATA_W, 32, sample and threshold width
PERSIST, 3, consecutive exceeding samples needed to raise an alarm (1..15)
SCAN_GAP, 16, idle cycles between scans (0 allowed)
TIMEOUT, 255, max cycles to wait for smp_ack (1..255)
HYST, 4, hysteresis margin, used only with the optional feature

Ports:
clk_sys  in  1  system clock
reset_clk_sys_n  in  1  asynchronous active-low reset
scan_en  in  1  level; 1 = run continuous scans
temp_threshold  in  32  channel 0 threshold
humidity_threshold  in  32  channel 1 threshold
dew_threshold  in  32  channel 2 threshold
soil_threshold  in  32  channel 3 threshold
water_threshold  in  32  channel 4 threshold
smp_req  out  1  sample request, held until ack or timeout
smp_ch  out  3  channel being requested, stable while smp_req=1
smp_ack  in  1  1-cycle pulse; smp_data valid in the same cycle
smp_data  in  32  sample value, unsigned
alarm  out  5  per-channel alarm, bit i = channel i
scan_done  out  1  1-cycle pulse after the last channel of a scan
timeout_err  out  5  sticky per-channel timeout flags
err_clr  in  1  clears all timeout_err bits (1 cycle)

Behaviour:
- Clock and reset: one clock, clk_sys. Reset is asynchronous, active-low, on reset_clk_sys_n.
- Reset values:
  - FSM = IDLE.
  - smp_req=0, smp_ch=0, alarm=0, scan_done=0, timeout_err=0.
  - All persist counters = 0, channel index = 0.
- FSM states:
  - IDLE: on scan_en=1 -> REQ, ch=0.
  - REQ: smp_req=1, smp_ch=ch.
    - smp_ack=1 -> capture smp_data, smp_req drops on the next edge, -> CMP.
    - Wait counter reaches TIMEOUT with no ack -> drop req, set timeout_err[ch], leave counter and alarm of ch unchanged, -> NEXT.
  - CMP (1 cycle): exceed = captured > threshold[ch], unsigned compare. Threshold is read live in this cycle.
    - exceed=1: counter saturating-increments at PERSIST; alarm[ch] sets when counter reaches PERSIST.
    - exceed=0: counter=0 and alarm[ch]=0. -> NEXT.
  - NEXT: ch<NUM_CH-1 -> ch+1, -> REQ.
    - Otherwise: scan_done=1 for this one cycle, ch=0, -> GAP (SCAN_GAP>0) or REQ/IDLE (SCAN_GAP=0).
  - GAP: count SCAN_GAP cycles, then REQ if scan_en else IDLE.
- Latency: ack sampled at edge N -> alarm visible after edge N+1 (CMP ends).
- Equal-to-threshold counts as not exceeding.
- scan_en deasserted mid-scan: the current channel finishes (handshake or timeout, then CMP), then -> IDLE, ch=0, no scan_done. Alarms hold their value.
- smp_ack outside REQ is ignored.
- err_clr and a timeout in the same cycle: the set wins for that bit.
- Reset mid-handshake: smp_req drops immediately (asynchronous).

Optional Feature:
SENSOR_SCAN_HYSTERESIS_EN.
- Defined: an active alarm clears only when sample < threshold - HYST, saturating at 0. Samples between that level and the threshold hold both counter and alarm.
- Undefined: clear rule exactly as in Behaviour; HYST is unused.

Decomposition:
- Package sensor_scan_pkg: FSM state enum (IDLE, REQ, CMP, NEXT, GAP), channel index constants CH_TEMP..CH_WATER, NUM_CH_C.
- Sub-module alarm_persist: one per channel, generate loop. Holds the saturating counter, the alarm flop and the hysteresis compare. Inputs: update strobe, sample, threshold.

Test Plan:
- Thresholds all 100, scan_en=1, acker returns 50 on all channels -> one smp_req per ch 0..4 in order; scan_done pulse; alarm=0; next smp_req after 16 gap cycles.
- ch1 returns 101 for 3 consecutive scans -> alarm[1]=1 after the third CMP; a following sample of 100 -> alarm[1]=0.
- ch3 exceeds twice, then 90, then exceeds twice -> alarm[3] never sets (counter restarts).
- Acker ignores ch2 -> smp_req drops after 255 cycles; timeout_err=5'b00100; scan continues to ch3; err_clr -> 0.
- scan_en dropped while ch2 awaiting ack; ack arrives 10 cycles later -> CMP runs, then IDLE, no scan_done, alarms held.
- With SENSOR_SCAN_HYSTERESIS_EN, threshold 100, alarm[0] set:
  - sample 97 -> alarm stays set.
  - sample 95 -> alarm clears.
